// File: rtl/add_round_key_collect.sv
// AES AddRoundKey collector: XORs four incoming mixed columns with a latched
// round key and emits the assembled 128-bit state with its round index.
module add_round_key_collect #(
  parameter int unsigned WORD     = 32,
  parameter int unsigned SENTENCE = 128,
  parameter int unsigned ROUNDS   = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic [SENTENCE-1:0] rk_in,
  input  logic                rk_valid,
  output logic                rk_ready,
  input  logic [WORD-1:0]     col_in,
  input  logic                col_valid,
  output logic                col_ready,
  output logic [SENTENCE-1:0] state_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [3:0]          out_round,
  output logic                out_last
);

  localparam logic [1:0] S_KEY  = 2'd0;
  localparam logic [1:0] S_COL  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam int unsigned NCOL     = SENTENCE / WORD;
  localparam logic [3:0]  RND_LAST = 4'(ROUNDS - 1);

  logic [1:0]          state_q, state_d;
  logic [SENTENCE-1:0] key_q, key_d;
  logic [SENTENCE-1:0] acc_q, acc_d;
  logic [1:0]          idx_q, idx_d;
  logic [3:0]          rnd_q, rnd_d;
  logic [SENTENCE-1:0] sout_q, sout_d;
  logic [3:0]          rout_q, rout_d;
  logic                last_q, last_d;
  logic                ovalid_q, ovalid_d;

  logic                rk_xfer, col_xfer, out_xfer, out_free;
  logic [WORD-1:0]     key_word, col_res;
  logic                emit;
  logic [SENTENCE-1:0] emit_val;

  // Handshake readiness depends on FSM state only, never on out_ready.
  assign rk_ready  = (state_q == S_KEY);
  assign col_ready = (state_q == S_COL);

  assign rk_xfer  = rk_valid && rk_ready;
  assign col_xfer = col_valid && col_ready;
  assign out_xfer = ovalid_q && out_ready;
  assign out_free = !ovalid_q || out_ready;

  assign state_out = sout_q;
  assign out_valid = ovalid_q;
  assign out_round = rout_q;
  assign out_last  = last_q;

  always_comb begin
    key_word = '0;
    for (int unsigned k = 0; k < NCOL; k++) begin
      if (idx_q == k[1:0]) key_word = key_q[SENTENCE-1-WORD*k -: WORD];
    end
    col_res = col_in ^ key_word;
  end

  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    rnd_d    = rnd_q;
    sout_d   = sout_q;
    rout_d   = rout_q;
    last_d   = last_q;
    ovalid_d = ovalid_q;
    emit     = 1'b0;
    emit_val = '0;

    if (out_xfer) ovalid_d = 1'b0;

    case (state_q)
      S_KEY: begin
        if (rk_xfer) begin
          key_d   = rk_in;
          idx_d   = '0;
          state_d = S_COL;
        end
      end
      S_COL: begin
        if (col_xfer) begin
          for (int unsigned k = 0; k < NCOL; k++) begin
            if (idx_q == k[1:0]) acc_d[SENTENCE-1-WORD*k -: WORD] = col_res;
          end
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            // Last column bypasses acc when the output register can take it now.
            if (out_free) begin
              emit     = 1'b1;
              emit_val = {acc_q[SENTENCE-1:WORD], col_res};
              state_d  = S_KEY;
            end else begin
              state_d = S_HOLD;
            end
          end
        end
      end
      S_HOLD: begin
        if (out_xfer) begin
          emit     = 1'b1;
          emit_val = acc_q;
          state_d  = S_KEY;
        end
      end
      default: state_d = S_KEY;
    endcase

    if (emit) begin
      sout_d   = emit_val;
      rout_d   = rnd_q;
      last_d   = (rnd_q == RND_LAST);
      ovalid_d = 1'b1;
      rnd_d    = (rnd_q == RND_LAST) ? '0 : rnd_q + 4'd1;
    end

    if (flush) begin
      state_d  = S_KEY;
      idx_d    = '0;
      rnd_d    = '0;
      ovalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_KEY;
      key_q    <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      rnd_q    <= '0;
      sout_q   <= '0;
      rout_q   <= '0;
      last_q   <= 1'b0;
      ovalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      rnd_q    <= rnd_d;
      sout_q   <= sout_d;
      rout_q   <= rout_d;
      last_q   <= last_d;
      ovalid_q <= ovalid_d;
    end
  end

endmodule

// File: tb/tb_add_round_key_collect.sv
// Scoreboard bench for add_round_key_collect: directed blocks push expected
// states; a negedge monitor pops and compares on every output handshake.
module tb_add_round_key_collect;

  logic         clk = 1'b0;
  logic         rst_n, flush;
  logic [127:0] rk_in;
  logic         rk_valid, rk_ready;
  logic [31:0]  col_in;
  logic         col_valid, col_ready;
  logic [127:0] state_out;
  logic         out_valid, out_ready;
  logic [3:0]   out_round;
  logic         out_last;

  always #5 clk = ~clk;

  add_round_key_collect #(.WORD(32), .SENTENCE(128), .ROUNDS(10)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .rk_in(rk_in), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .col_in(col_in), .col_valid(col_valid), .col_ready(col_ready),
    .state_out(state_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_round(out_round), .out_last(out_last)
  );

  typedef struct packed {
    logic [127:0] s;
    logic [3:0]   r;
    logic         l;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_rnd = 0;

  localparam logic [127:0] V_KEY = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] V_COL = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] V_EXP = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] A_KEY = 128'hffffffffffffffffffffffffffffffff;
  localparam logic [127:0] A_COL = 128'h00000000111111112222222233333333;
  localparam logic [127:0] A_EXP = 128'hffffffffeeeeeeeeddddddddcccccccc;
  localparam logic [127:0] B_KEY = 128'h0f0f0f0ff0f0f0f01234567800000000;
  localparam logic [127:0] B_COL = 128'hf0f0f0f00f0f0f0f12345678cafebabe;
  localparam logic [127:0] B_EXP = 128'hffffffffffffffff00000000cafebabe;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic push(input logic [127:0] s);
    exp_t e;
    e.s = s;
    e.r = 4'(exp_rnd);
    e.l = (exp_rnd == 9);
    q.push_back(e);
    exp_rnd = (exp_rnd + 1) % 10;
  endtask

  task automatic send_key(input logic [127:0] k);
    int n = 0;
    logic got = 1'b0;
    rk_in = k;
    rk_valid = 1'b1;
    while (!got && n < 50) begin
      @(negedge clk);
      got = rk_ready;
      @(posedge clk);
      #1;
      n++;
    end
    rk_valid = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL key_timeout: got no rk_ready expected rk_ready within 50 cycles");
    end
  endtask

  task automatic send_col(input logic [31:0] w, input logic fl);
    int n = 0;
    logic got = 1'b0;
    col_in = w;
    col_valid = 1'b1;
    flush = fl;
    while (!got && n < 50) begin
      @(negedge clk);
      got = col_ready;
      @(posedge clk);
      #1;
      n++;
    end
    col_valid = 1'b0;
    flush = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL col_timeout: got no col_ready expected col_ready within 50 cycles");
    end
  endtask

  task automatic send_block(input logic [127:0] k, input logic [127:0] cols, input logic [127:0] expv);
    push(expv);
    send_key(k);
    for (int i = 0; i < 4; i++) send_col(cols[127-32*i -: 32], 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while (out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (out_valid) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got out_valid=1 expected 0 within 50 cycles");
    end
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    exp_rnd = 0;
  endtask

  // Monitor: one comparison set per output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: got state %h expected no output", state_out);
        end else begin
          e = q.pop_front();
          chk("mon_state", state_out, e.s);
          chk("mon_round", 128'(out_round), 128'(e.r));
          chk("mon_last", 128'(out_last), 128'(e.l));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; rk_in = '0; rk_valid = 1'b0;
    col_in = '0; col_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("rst_rk_ready", 128'(rk_ready), 128'd1);
    chk("rst_col_ready", 128'(col_ready), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_state_out", state_out, 128'd0);
    chk("rst_out_round", 128'(out_round), 128'd0);
    chk("rst_out_last", 128'(out_last), 128'd0);
    rst_n = 1'b1;

    // Idle column guard: data offered before any key must be ignored.
    col_in = 32'hdeadbeef;
    col_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_col_ready", 128'(col_ready), 128'd0);
      @(posedge clk); #1;
    end
    col_valid = 1'b0;

    // Key-add vector with latency check.
    send_block(V_KEY, V_COL, V_EXP);
    chk("latency_valid", 128'(out_valid), 128'd1);
    drain();

    // Stall through two blocks.
    pulse_flush();
    out_ready = 1'b0;
    send_block(A_KEY, A_COL, A_EXP);
    chk("stall_a_valid", 128'(out_valid), 128'd1);
    chk("stall_a_state", state_out, A_EXP);
    send_block(B_KEY, B_COL, B_EXP);
    chk("hold_col_ready", 128'(col_ready), 128'd0);
    chk("hold_rk_ready", 128'(rk_ready), 128'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("stall_a_stable", state_out, A_EXP);
      chk("stall_a_round", 128'(out_round), 128'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("reload_valid", 128'(out_valid), 128'd1);
    chk("reload_state", state_out, B_EXP);
    chk("reload_round", 128'(out_round), 128'd1);
    chk("reload_rk_ready", 128'(rk_ready), 128'd1);
    out_ready = 1'b1;
    drain();

    // Round wrap over 11 zero blocks.
    pulse_flush();
    for (int i = 0; i < 11; i++) send_block('0, '0, '0);
    drain();

    // Flush after two columns.
    send_key(V_KEY);
    send_col(V_COL[127:96], 1'b0);
    send_col(V_COL[95:64], 1'b0);
    pulse_flush();
    chk("flush_out_valid", 128'(out_valid), 128'd0);
    chk("flush_rk_ready", 128'(rk_ready), 128'd1);
    chk("flush_col_ready", 128'(col_ready), 128'd0);
    send_block(V_KEY, V_COL, V_EXP);
    drain();

    // Reset after two columns.
    send_key(A_KEY);
    send_col(A_COL[127:96], 1'b0);
    send_col(A_COL[95:64], 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", 128'(out_valid), 128'd0);
    chk("mrst_rk_ready", 128'(rk_ready), 128'd1);
    chk("mrst_col_ready", 128'(col_ready), 128'd0);
    chk("mrst_state_out", state_out, 128'd0);
    chk("mrst_out_round", 128'(out_round), 128'd0);
    exp_rnd = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_block(A_KEY, A_COL, A_EXP);
    drain();

    // Flush coincident with the 4th column transfer.
    send_key(B_KEY);
    send_col(B_COL[127:96], 1'b0);
    send_col(B_COL[95:64], 1'b0);
    send_col(B_COL[63:32], 1'b0);
    send_col(B_COL[31:0], 1'b1);
    exp_rnd = 0;
    chk("fprio_rk_ready", 128'(rk_ready), 128'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("fprio_out_valid", 128'(out_valid), 128'd0);
    end
    @(posedge clk); #1;
    send_block(B_KEY, B_COL, B_EXP);
    drain();

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 128'(q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/add_round_key_collect.md
# add_round_key_collect

Sequential AES AddRoundKey stage that sits directly downstream of the 32-bit column mixer. It accepts one mixed column per cycle over a valid/ready handshake and XORs each column with the matching word of a 128-bit round key. It assembles the four results into a 128-bit state and presents the state, tagged with its round index, over an output valid/ready handshake. A 128-bit output register decouples the next block's collection from output back-pressure.

## Interface
- WORD, 32, column width in bits
- SENTENCE, 128, state and round-key width in bits (always 4*WORD)
- ROUNDS, 10, number of round indices before the round counter wraps
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous abort: drop key, partial state, output and round count
- rk_in  in  SENTENCE  round key; word 0 = rk_in[127:96]
- rk_valid  in  1  rk_in valid
- rk_ready  out  1  block will latch rk_in this cycle
- col_in  in  WORD  mixed column from the column mixer
- col_valid  in  1  col_in valid
- col_ready  out  1  block will accept col_in this cycle
- state_out  out  SENTENCE  key-added state; column 0 = state_out[127:96]
- out_valid  out  1  state_out valid
- out_ready  in  1  downstream accepts state_out
- out_round  out  4  round index of state_out (0..ROUNDS-1)
- out_last  out  1  out_round == ROUNDS-1

## Operation
- A transfer occurs on any edge where valid && ready.
- The FSM has three states: S_KEY, S_COL, S_HOLD.
- S_KEY
  - rk_ready=1, col_ready=0.
  - On rk transfer: latch rk_in into key_r, clear idx to 0, go to S_COL.
- S_COL
  - rk_ready=0, col_ready=1.
  - On col transfer: acc word[idx] <= col_in ^ key_r word[idx], then idx++.
  - idx 0..2: stay in S_COL.
  - idx 3, output register free (out_valid==0, or out_valid && out_ready this edge):
    - state_out <= {acc0, acc1, acc2, col_in ^ key_r word3}
    - out_round <= rnd; out_valid <= 1; rnd advances; go to S_KEY.
  - idx 3, output register occupied: store word 3 into acc and go to S_HOLD.
- S_HOLD
  - rk_ready=0, col_ready=0.
  - On the edge where out_valid && out_ready: load state_out from acc, set out_round and out_valid, advance rnd, go to S_KEY.
- Word mapping: column k uses key_r[127-32k -: 32] and lands at state_out[127-32k -: 32].
- rnd counter: 4-bit, increments per emitted block, wraps from ROUNDS-1 to 0.
- out_last is registered alongside out_round.
- An output handshake with no reload clears out_valid on that edge.
- state_out, out_round and out_last hold while out_valid && !out_ready.
- flush has priority over every handshake on the same edge:
  - state returns to S_KEY; idx, rnd and out_valid go to 0.
  - acc and key_r contents are don't-care.
- Width rule: pure bitwise XOR, no carries. Inputs are never modified except on a transfer.

## Timing
- Reset values (asynchronous, immediate on rst_n low):
  - FSM = S_KEY, rk_ready=1, col_ready=0, out_valid=0
  - state_out=0, out_round=0, out_last=0, idx=0, rnd=0
- rk_ready and col_ready are combinational from FSM state only, never from out_ready.
- Minimum block cost is 5 cycles: 1 key cycle + 4 column cycles.
- Latency: out_valid rises the cycle after the 4th column transfer when the output register is free.
- With output stalled, out_valid reloads the cycle after the draining handshake.
- Back-to-back: the next key can be accepted the cycle after the 4th column, while the previous state is still held in the output register.
- col_valid asserted in S_KEY or S_HOLD is ignored; it is not a transfer.
- Reset mid-block discards everything. Output returns to reset values with no partial emission.

## Test plan
- Key-add vector:
  - Stimulus: rk=a0fafe1788542cb123a339392a6c7605; columns 046681e5, e0cb199a, 48f8d37a, 2806264c; out_ready=1.
  - Required: state_out=a49c7ff2689f352b6b5bea43026a5049, out_round=0, out_valid exactly 1 cycle after the 4th column.
- Stall:
  - Stimulus: out_ready=0 through two full blocks.
  - Required: the first block holds stable; after the second block's 4th column, FSM is S_HOLD and col_ready=0.
  - Then out_ready=1 for 1 cycle: the second block appears the next cycle with out_round=1.
- Round wrap:
  - Stimulus: 11 blocks, all-zero keys and columns.
  - Required: out_round reads 0..9 then 0; out_last=1 only on the 10th block.
- Idle-column guard:
  - Stimulus: col_valid=1 with data deadbeef asserted before any key.
  - Required: no transfer, col_ready=0; the next block's result is unaffected.
- Flush / reset mid-block:
  - Stimulus: flush after 2 columns; repeat the test with rst_n low after 2 columns.
  - Required: out_valid=0, rk_ready=1, rnd=0; the following clean block emits out_round=0 with a correct value.
- Flush-priority edge:
  - Stimulus: flush coincident with the 4th col transfer.
  - Required: no output emitted.
